mux_sel_sequencer: RTL and testbench
====================================

# mux_sel_sequencer

Upstream driver for the 8:1 bit-select mux. Accepts an 8-bit word with a length and bit-order control over a valid/ready load handshake, then presents the word on `mux_in` and steps `mux_sel` one position per accepted bit. The mux combinationally produces the serial bit, and `bit_valid`/`bit_ready` qualify it to the downstream consumer. Together the two blocks form a parallel-to-serial path with backpressure and optional inter-bit gaps.

## Interface
- `GAP`, default 0: idle cycles inserted between consecutive bits of one word. Legal range 0–15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_valid` in 1: upstream word available.
- `load_data` in 8: word to serialize.
- `load_len` in 3: number of bits minus 1. 0 means 1 bit; 7 means 8 bits.
- `msb_first` in 1: 1 starts at sel 7 and decrements; 0 starts at sel 0 and increments.
- `load_ready` out 1: block can accept a word.
- `mux_in` out 8: latched word, drives the mux data input.
- `mux_sel` out 3: current bit index, drives the mux select.
- `bit_valid` out 1: mux output is a valid serial bit this cycle.
- `bit_ready` in 1: consumer accepts the bit.
- `bit_last` out 1: current valid bit is the final bit of the word.
- `busy` out 1: word in progress (state ≠ IDLE).
- `done` out 1: one-cycle pulse after the final bit transfers.

## Operation
- **States**
  - IDLE: `load_ready`=1.
  - SHIFT: `bit_valid`=1.
  - GAP: `bit_valid`=0, gap counter running.
- **Load.** Occurs on `load_valid && load_ready`, sampled at a rising edge.
  - Latch `load_data` into `mux_in`, `load_len` into len, `msb_first` into order.
  - Set `mux_sel` to 7 (MSB-first) or 0 (LSB-first); clear bit count to 0.
  - Next state: SHIFT.
- **Bit transfer.** Occurs on `bit_valid && bit_ready` in SHIFT.
  - If bit count == len: go to IDLE and pulse `done` for the next cycle.
  - Else: bit count +1, `mux_sel` ±1 per latched order. Go to GAP if `GAP`>0, otherwise stay in SHIFT.
- **GAP state.** Counts `GAP` cycles, then returns to SHIFT. `mux_sel` already holds the next index.
- **Bit last.** `bit_last` = `bit_valid` && (bit count == len).
- **Index range.** `mux_sel` never wraps: at most 8 bits are sent, and the index stays within 0..7 for both orders.
- **Load gating.** `load_valid` is ignored while busy. A new word can be accepted no earlier than the cycle in which `done` is high.
- **Hold after done.** `mux_in` and `mux_sel` keep their last values in IDLE until the next load.
- **Latched controls.** `load_len` and `msb_first` are sampled only at load. Changes mid-word have no effect.

## Timing
- **Reset.** `rst`=1 at an edge forces IDLE.
  - `mux_in`=0, `mux_sel`=0, `bit_valid`=0, `bit_last`=0, `busy`=0, `done`=0, counters cleared.
  - `load_ready` = (state==IDLE). It may read 1 during reset, but loads are ignored while `rst`=1.
- **Reset mid-word.** The word is abandoned in the cycle after the edge: no `done`, no further `bit_valid`.
- **Load latency.** A load accepted at edge N gives `bit_valid`=1 from cycle N+1, with `mux_in`/`mux_sel` valid in the same cycle.
- **Throughput.** With `GAP`=0 and `bit_ready` held at 1: one bit per cycle. An 8-bit word takes 8 cycles; `done` is high in cycle 9.
- **Word duration with gaps.** (len+1) + len·`GAP` cycles of SHIFT/GAP, assuming no backpressure.
- **Backpressure.** While `bit_valid && !bit_ready`: `mux_in`, `mux_sel`, `bit_valid` and `bit_last` hold stable. No bit is skipped or repeated.
- **Rst priority.** `rst` overrides a simultaneous load or bit transfer.
- **Done and load overlap.** `done` and `load_ready` are both high in the first IDLE cycle. A load in that cycle gives `bit_valid` on the following cycle.

## Test plan
- **Reset.** Hold `rst` 2 cycles with `load_valid`=1 → no load; `mux_in`=0x00, `mux_sel`=0, `bit_valid`=0, `busy`=0, `done`=0.
- **LSB-first full word.** Load 0xA5, len=7, `msb_first`=0, `bit_ready`=1 → `mux_sel` 0..7 over 8 consecutive cycles; mux out 1,0,1,0,0,1,0,1; `bit_last` only at sel 7; `done` one cycle later.
- **MSB-first partial word.** Load 0xC3, len=2, `msb_first`=1 → `mux_sel` 7,6,5; bits 1,1,0; `bit_last` at sel 5; `done` next cycle. Toggle `load_valid` mid-word → it is ignored.
- **Backpressure.** Load 0x5A with `bit_ready` low for 3 cycles at sel 3 → sel stays 3 and `bit_valid` stays 1; 8 bits total delivered in order.
- **Gap build.** `GAP`=2, load 0xFF, len=7 → two `bit_valid`=0 cycles between bits; 22 cycles from first `bit_valid` to `done`.
- **Reset mid-word.** Assert `rst` during bit 4 → IDLE next cycle, no `done`. A new load of 0x01, LSB-first, starts at sel 0.

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// Parallel-to-serial front end for an 8:1 bit-select mux: latches a word over a
// valid/ready load handshake, then steps mux_sel once per accepted bit.
module mux_sel_sequencer #(
    parameter int unsigned GAP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic [2:0] load_len,
    input  logic       msb_first,
    output logic       load_ready,
    output logic [7:0] mux_in,
    output logic [2:0] mux_sel,
    output logic       bit_valid,
    input  logic       bit_ready,
    output logic       bit_last,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    // Entering ST_GAP loads GAP-1 so the state lasts exactly GAP cycles.
    localparam logic [3:0] GAP_RELOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    state_t     state_q, state_d;
    logic [7:0] mux_in_q, mux_in_d;
    logic [2:0] mux_sel_q, mux_sel_d;
    logic [2:0] len_q, len_d;
    logic       order_q, order_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       done_q, done_d;

    always_comb begin
        state_d   = state_q;
        mux_in_d  = mux_in_q;
        mux_sel_d = mux_sel_q;
        len_d     = len_q;
        order_d   = order_q;
        cnt_d     = cnt_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    mux_in_d  = load_data;
                    len_d     = load_len;
                    order_d   = msb_first;
                    mux_sel_d = msb_first ? 3'd7 : 3'd0;
                    cnt_d     = 3'd0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_ready) begin
                    if (cnt_q == len_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + 3'd1;
                        mux_sel_d = order_q ? (mux_sel_q - 3'd1) : (mux_sel_q + 3'd1);
                        if (GAP > 0) begin
                            gap_cnt_d = GAP_RELOAD;
                            state_d   = ST_GAP;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = ST_SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mux_in_q  <= '0;
            mux_sel_q <= '0;
            len_q     <= '0;
            order_q   <= 1'b0;
            cnt_q     <= '0;
            gap_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mux_in_q  <= mux_in_d;
            mux_sel_q <= mux_sel_d;
            len_q     <= len_d;
            order_q   <= order_d;
            cnt_q     <= cnt_d;
            gap_cnt_q <= gap_cnt_d;
            done_q    <= done_d;
        end
    end

    assign load_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign bit_valid  = (state_q == ST_SHIFT);
    assign bit_last   = bit_valid && (cnt_q == len_q);
    assign mux_in     = mux_in_q;
    assign mux_sel    = mux_sel_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer: one instance with GAP=0, one with GAP=2.
module tb_mux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid, load_valid2;
    logic [7:0] load_data;
    logic [2:0] load_len;
    logic       msb_first;
    logic       bit_ready, bit_ready2;

    logic       load_ready, bit_valid, bit_last, busy, done;
    logic [7:0] mux_in;
    logic [2:0] mux_sel;

    logic       load_ready2, bit_valid2, bit_last2, busy2, done2;
    logic [7:0] mux_in2;
    logic [2:0] mux_sel2;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    mux_sel_sequencer #(.GAP(0)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_len(load_len), .msb_first(msb_first), .load_ready(load_ready),
        .mux_in(mux_in), .mux_sel(mux_sel), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .bit_last(bit_last), .busy(busy), .done(done)
    );

    mux_sel_sequencer #(.GAP(2)) dut_gap (
        .clk(clk), .rst(rst), .load_valid(load_valid2), .load_data(load_data),
        .load_len(load_len), .msb_first(msb_first), .load_ready(load_ready2),
        .mux_in(mux_in2), .mux_sel(mux_sel2), .bit_valid(bit_valid2),
        .bit_ready(bit_ready2), .bit_last(bit_last2), .busy(busy2), .done(done2)
    );

    wire serial_bit  = mux_in[mux_sel];
    wire serial_bit2 = mux_in2[mux_sel2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_mux_in"}, 32'(mux_in), 32'h00);
        chk({tag, "_mux_sel"}, 32'(mux_sel), 32'd0);
        chk({tag, "_bit_valid"}, 32'(bit_valid), 32'd0);
        chk({tag, "_bit_last"}, 32'(bit_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Hand-computed serial streams
    logic a5_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic c3_bits [3] = '{1'b1, 1'b1, 1'b0};
    logic [2:0] c3_sel [3] = '{3'd7, 3'd6, 3'd5};
    logic s5a_bits [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst = 1'b1; load_valid = 1'b1; load_valid2 = 1'b0;
        load_data = 8'hFF; load_len = 3'd7; msb_first = 1'b1;
        bit_ready = 1'b1; bit_ready2 = 1'b1;

        // Reset held two cycles with a load pending
        tick(); chk_idle_reset("rst1");
        tick(); chk_idle_reset("rst2");
        load_valid = 1'b0;
        rst = 1'b0;
        tick(); chk_idle_reset("post_rst");
        chk("post_rst_load_ready", 32'(load_ready), 32'd1);

        // LSB-first full word 0xA5
        load_valid = 1'b1; load_data = 8'hA5; load_len = 3'd7; msb_first = 1'b0;
        tick();
        load_valid = 1'b0;
        chk("a5_busy", 32'(busy), 32'd1);
        chk("a5_load_ready", 32'(load_ready), 32'd0);
        chk("a5_mux_in", 32'(mux_in), 32'hA5);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a5_valid%0d", i), 32'(bit_valid), 32'd1);
            chk($sformatf("a5_sel%0d", i), 32'(mux_sel), 32'(i));
            chk($sformatf("a5_bit%0d", i), 32'(serial_bit), 32'(a5_bits[i]));
            chk($sformatf("a5_last%0d", i), 32'(bit_last), (i == 7) ? 32'd1 : 32'd0);
            chk($sformatf("a5_done%0d", i), 32'(done), 32'd0);
            tick();
        end
        chk("a5_done", 32'(done), 32'd1);
        chk("a5_done_valid", 32'(bit_valid), 32'd0);
        chk("a5_done_ready", 32'(load_ready), 32'd1);
        chk("a5_hold_in", 32'(mux_in), 32'hA5);
        chk("a5_hold_sel", 32'(mux_sel), 32'd7);
        tick();
        chk("a5_done_pulse", 32'(done), 32'd0);
        chk("a5_idle_busy", 32'(busy), 32'd0);

        // MSB-first partial word 0xC3, len 2, with a spurious load mid-word
        load_valid = 1'b1; load_data = 8'hC3; load_len = 3'd2; msb_first = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                load_valid = 1'b1; load_data = 8'h00; load_len = 3'd7; msb_first = 1'b0;
            end
            if (i == 2) load_valid = 1'b0;
            chk($sformatf("c3_valid%0d", i), 32'(bit_valid), 32'd1);
            chk($sformatf("c3_sel%0d", i), 32'(mux_sel), 32'(c3_sel[i]));
            chk($sformatf("c3_bit%0d", i), 32'(serial_bit), 32'(c3_bits[i]));
            chk($sformatf("c3_last%0d", i), 32'(bit_last), (i == 2) ? 32'd1 : 32'd0);
            chk($sformatf("c3_in%0d", i), 32'(mux_in), 32'hC3);
            tick();
        end
        chk("c3_done", 32'(done), 32'd1);
        chk("c3_hold_in", 32'(mux_in), 32'hC3);
        chk("c3_hold_sel", 32'(mux_sel), 32'd5);

        // Load in the done cycle, then backpressure at sel 3
        load_valid = 1'b1; load_data = 8'h5A; load_len = 3'd7; msb_first = 1'b0;
        tick();
        load_valid = 1'b0;
        chk("5a_overlap_valid", 32'(bit_valid), 32'd1);
        chk("5a_overlap_done", 32'(done), 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                bit_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk($sformatf("bp_sel%0d", k), 32'(mux_sel), 32'd3);
                    chk($sformatf("bp_valid%0d", k), 32'(bit_valid), 32'd1);
                    chk($sformatf("bp_last%0d", k), 32'(bit_last), 32'd0);
                    chk($sformatf("bp_in%0d", k), 32'(mux_in), 32'h5A);
                end
                bit_ready = 1'b1;
            end
            chk($sformatf("5a_sel%0d", i), 32'(mux_sel), 32'(i));
            chk($sformatf("5a_bit%0d", i), 32'(serial_bit), 32'(s5a_bits[i]));
            chk($sformatf("5a_last%0d", i), 32'(bit_last), (i == 7) ? 32'd1 : 32'd0);
            tick();
        end
        chk("5a_done", 32'(done), 32'd1);
        tick();

        // Reset while sel 4 is on the bus (MSB-first 0x0F)
        load_valid = 1'b1; load_data = 8'h0F; load_len = 3'd7; msb_first = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("rmw_sel4", 32'(mux_sel), 32'd4);
        chk("rmw_valid", 32'(bit_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_reset("rmw_rst");
        tick();
        chk("rmw_no_done", 32'(done), 32'd0);
        chk("rmw_no_valid", 32'(bit_valid), 32'd0);
        load_valid = 1'b1; load_data = 8'h01; load_len = 3'd0; msb_first = 1'b0;
        tick();
        load_valid = 1'b0;
        chk("new_sel", 32'(mux_sel), 32'd0);
        chk("new_valid", 32'(bit_valid), 32'd1);
        chk("new_bit", 32'(serial_bit), 32'd1);
        chk("new_last", 32'(bit_last), 32'd1);
        tick();
        chk("new_done", 32'(done), 32'd1);

        // GAP=2 instance: 0xFF, len 7, LSB-first
        load_valid2 = 1'b1; load_data = 8'hFF; load_len = 3'd7; msb_first = 1'b0;
        tick();
        load_valid2 = 1'b0;
        for (int c = 0; c < 22; c++) begin
            chk($sformatf("gap_valid%0d", c), 32'(bit_valid2), (c % 3 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("gap_done%0d", c), 32'(done2), 32'd0);
            if (c % 3 == 0) begin
                chk($sformatf("gap_sel%0d", c), 32'(mux_sel2), 32'(c / 3));
                chk($sformatf("gap_bit%0d", c), 32'(serial_bit2), 32'd1);
            end
            tick();
        end
        chk("gap_done", 32'(done2), 32'd1);
        chk("gap_done_valid", 32'(bit_valid2), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
